// File: rtl/data_ram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp_pkg
// Description : Shared definitions for the data memory responder. Holds the
//               FSM state encodings, the data width and the byte-enable
//               patterns that count as naturally aligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_resp_pkg;

    localparam int DRAM_DATA_W = 32;
    localparam int DRAM_SEL_W  = DRAM_DATA_W / 8;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_WAIT = 2'd1,
        DRAM_ACK  = 2'd2
    } dram_state_e;

    // Aligned byte-enable patterns: single bytes, aligned halves, full word.
    localparam logic [DRAM_SEL_W-1:0] DRAM_SEL_B0 = 4'b0001;
    localparam logic [DRAM_SEL_W-1:0] DRAM_SEL_B1 = 4'b0010;
    localparam logic [DRAM_SEL_W-1:0] DRAM_SEL_B2 = 4'b0100;
    localparam logic [DRAM_SEL_W-1:0] DRAM_SEL_B3 = 4'b1000;
    localparam logic [DRAM_SEL_W-1:0] DRAM_SEL_H0 = 4'b0011;
    localparam logic [DRAM_SEL_W-1:0] DRAM_SEL_H1 = 4'b1100;
    localparam logic [DRAM_SEL_W-1:0] DRAM_SEL_W0 = 4'b1111;

    function automatic logic dram_sel_legal(input logic [DRAM_SEL_W-1:0] sel);
        logic ok;
        ok = 1'b0;
        case (sel)
            DRAM_SEL_B0, DRAM_SEL_B1, DRAM_SEL_B2, DRAM_SEL_B3,
            DRAM_SEL_H0, DRAM_SEL_H1, DRAM_SEL_W0: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_bank.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_bank
// Description : DEPTH x 32 single-port array with per-byte write enables and
//               registered read-before-write output.
// Ports       : clk, rst (sync, active-high; clears only the read register
//               and blocks writes), en_i (access strobe), we_i[3:0] (byte
//               write enables), addr_i (word address), wdata_i, rdata_o.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_bank
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [DRAM_SEL_W-1:0]  we_i,
    input  logic [DEPTH_LOG2-1:0]  addr_i,
    input  logic [DRAM_DATA_W-1:0] wdata_i,
    output logic [DRAM_DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DRAM_DATA_W-1:0] mem [DEPTH];
    logic [DRAM_DATA_W-1:0] rdata_q;

    // Read register: captures the old word on every access edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    // Array contents are never reset; rst only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!rst && en_i) begin
            for (int i = 0; i < DRAM_SEL_W; i++) begin
                if (we_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp
// Description : Word-addressed data memory responding to MEM-stage requests
//               with a programmable number of wait states and a one-cycle
//               acknowledge. Build option DATA_RAM_ALIGN_CHECK_EN flags
//               non-aligned byte-enable patterns as errors.
// Ports       : clk, rst (sync, active-high), req_i, we_i, addr_i[31:0],
//               sel_i[3:0], wdata_i[31:0] -> ack_o, rdata_o[31:0], busy_o,
//               err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [31:0]            addr_i,
    input  logic [DRAM_SEL_W-1:0]  sel_i,
    input  logic [DRAM_DATA_W-1:0] wdata_i,
    output logic                   ack_o,
    output logic [DRAM_DATA_W-1:0] rdata_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dram_state_e            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   commit;

    logic                   we_q;
    logic [DEPTH_LOG2-1:0]  addr_q;
    logic [DRAM_SEL_W-1:0]  sel_q;
    logic [DRAM_DATA_W-1:0] wdata_q;

    // Access attributes seen by the array on the commit edge.
    logic                   acc_we;
    logic [DEPTH_LOG2-1:0]  acc_addr;
    logic [DRAM_SEL_W-1:0]  acc_sel;
    logic [DRAM_DATA_W-1:0] acc_wdata;
    logic                   acc_illegal;
    logic [DRAM_SEL_W-1:0]  bank_we;
    logic [DRAM_DATA_W-1:0] bank_rdata;

    // Upper address bits and the byte offset only alias.
    logic                   w_unused_addr;
    assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRAM_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == DRAM_IDLE && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i[DEPTH_LOG2+1:2];
                sel_q   <= sel_i;
                wdata_q <= wdata_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            DRAM_IDLE: begin
                if (req_i) begin
                    cnt_d = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the access commits on the
                        // acceptance edge itself, using the live inputs.
                        commit  = 1'b1;
                        state_d = DRAM_ACK;
                    end else begin
                        state_d = DRAM_WAIT;
                    end
                end
            end
            DRAM_WAIT: begin
                // <= 1 also recovers from an (unreachable) zero count.
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = '0;
                    state_d = DRAM_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DRAM_ACK: begin
                state_d = DRAM_IDLE;
            end
            default: begin
                state_d = DRAM_IDLE;
            end
        endcase
    end

    generate
        if (WAIT_CYCLES == 0) begin : g_zero_wait
            assign acc_we    = we_i;
            assign acc_addr  = addr_i[DEPTH_LOG2+1:2];
            assign acc_sel   = sel_i;
            assign acc_wdata = wdata_i;
        end else begin : g_wait
            assign acc_we    = we_q;
            assign acc_addr  = addr_q;
            assign acc_sel   = sel_q;
            assign acc_wdata = wdata_q;
        end
    endgenerate

`ifdef DATA_RAM_ALIGN_CHECK_EN
    logic err_q;

    assign acc_illegal = !dram_sel_legal(acc_sel);

    // Error flag follows the same commit timing as the read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= acc_illegal;
        end
    end

    assign err_o   = err_q && (state_q == DRAM_ACK);
    assign rdata_o = err_q ? '0 : bank_rdata;
`else
    assign acc_illegal = 1'b0;
    assign err_o       = 1'b0;
    assign rdata_o     = bank_rdata;
`endif

    assign bank_we = (acc_we && !acc_illegal) ? acc_sel : '0;

    data_ram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .en_i    (commit),
        .we_i    (bank_we),
        .addr_i  (acc_addr),
        .wdata_i (acc_wdata),
        .rdata_o (bank_rdata)
    );

    assign ack_o  = (state_q == DRAM_ACK);
    assign busy_o = (state_q != DRAM_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_resp
// Description : Directed self-checking bench for data_ram_resp with
//               WAIT_CYCLES=2, DEPTH_LOG2=10. Expected values for the
//               unaligned store depend on DATA_RAM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_resp;

    localparam int WAITS   = 2;
    localparam int EXP_LAT = WAITS + 2;  // request cycle counted as cycle 1

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        err_o;

    int n_checks;
    int n_fail;
    int cyc;

    data_ram_resp #(
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .sel_i   (sel_i),
        .wdata_i (wdata_i),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drives one access from the next falling edge, waits for ack (bounded),
    // drops req in the ack cycle. lat counts the request cycle as 1.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int ack_cyc);
        @(negedge clk);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        sel_i   = sel;
        wdata_i = wdata;
        lat     = 1;
        rdata   = '0;
        err     = 1'b0;
        ack_cyc = -1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack_o) begin
                rdata   = rdata_o;
                err     = err_o;
                ack_cyc = cyc;
                break;
            end
        end
        req_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        er;
        int          lat, ac;
        logic        seen;
        n_checks++;
        if ({ack_o, busy_o, err_o, rdata_o} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b busy=%b err=%b rdata=%h, want all 0",
                     ack_o, busy_o, err_o, rdata_o);
        end
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; sel_i = 4'hF; wdata_i = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_in_wait: got %b want 1", busy_o);
        end
        req_i = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ack_o, busy_o, err_o, rdata_o} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_midwait_outputs: got ack=%b busy=%b err=%b rdata=%h, want all 0",
                     ack_o, busy_o, err_o, rdata_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_o || busy_o) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abandon: got ack/busy activity=%b want 0", seen);
        end
        do_access(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (rd === 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL reset_no_write: got %h, want anything but deadbeef", rd);
        end
    endtask

    task automatic test_full_word;
        logic [31:0] rd;
        logic        er;
        int          lat, ac;
        do_access(1'b1, 32'h40, 4'hF, 32'h12345678, rd, er, lat, ac);
        n_checks++;
        if (lat !== EXP_LAT || er !== 1'b0) begin
            n_fail++;
            $display("FAIL word_store_lat: got lat=%0d err=%b want lat=%0d err=0", lat, er, EXP_LAT);
        end
        do_access(1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL word_load_lat: got %0d want %0d", lat, EXP_LAT);
        end
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL word_load_data: got %h want 12345678", rd);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rdata_o !== 32'h12345678 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rdata_hold: got rdata=%h busy=%b want 12345678 busy=0", rdata_o, busy_o);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd;
        logic        er;
        int          lat, ac;
        do_access(1'b1, 32'h40, 4'b0001, 32'h000000AA, rd, er, lat, ac);
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL store_read_before_write: got %h want 12345678", rd);
        end
        do_access(1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (rd !== 32'h123456AA) begin
            n_fail++;
            $display("FAIL byte_lane_load: got %h want 123456aa", rd);
        end
        do_access(1'b1, 32'h42, 4'b1100, 32'hBEEF0000, rd, er, lat, ac);
        do_access(1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (rd !== 32'hBEEF56AA) begin
            n_fail++;
            $display("FAIL half_lane_load: got %h want beef56aa", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        er;
        int          lat, ac1, ac2;
        do_access(1'b1, 32'h0, 4'hF, 32'h1, rd, er, lat, ac1);
        do_access(1'b0, 32'h1000, 4'hF, 32'h0, rd, er, lat, ac2);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL alias_load: got %h want 00000001", rd);
        end
        n_checks++;
        if (ac2 - ac1 !== EXP_LAT) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", ac2 - ac1, EXP_LAT);
        end
        do_access(1'b0, 32'hFFFF_F003, 4'hF, 32'h0, rd, er, lat, ac1);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL alias_high_bits: got %h want 00000001", rd);
        end
    endtask

    task automatic test_held_request;
        int          first, second;
        logic [31:0] rd2;
        first  = -1;
        second = -1;
        rd2    = '0;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h80; sel_i = 4'hF; wdata_i = 32'h55;
        for (int i = 0; i < 40 && second < 0; i++) begin
            @(negedge clk);
            if (ack_o) begin
                if (first < 0) begin
                    first = cyc;
                end else begin
                    second = cyc;
                    rd2    = rdata_o;
                end
            end
        end
        req_i = 1'b0;
        n_checks++;
        if (second < 0 || second - first !== EXP_LAT) begin
            n_fail++;
            $display("FAIL held_req_spacing: got first=%0d second=%0d want spacing %0d",
                     first, second, EXP_LAT);
        end
        n_checks++;
        if (rd2 !== 32'h55) begin
            n_fail++;
            $display("FAIL held_req_second_rdata: got %h want 00000055", rd2);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL held_req_no_third: got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_unaligned_sel;
        logic [31:0] rd;
        logic        er;
        int          lat, ac;
        do_access(1'b1, 32'h40, 4'b0101, 32'h11223344, rd, er, lat, ac);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL unaligned_lat: got %0d want %0d", lat, EXP_LAT);
        end
`ifdef DATA_RAM_ALIGN_CHECK_EN
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL unaligned_err: got err=%b rdata=%h want err=1 rdata=0", er, rd);
        end
        do_access(1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (rd !== 32'hBEEF56AA || er !== 1'b0) begin
            n_fail++;
            $display("FAIL unaligned_readback: got %h err=%b want beef56aa err=0", rd, er);
        end
        do_access(1'b0, 32'h40, 4'b0000, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL sel0_load: got %h err=%b want 0 err=1", rd, er);
        end
`else
        n_checks++;
        if (er !== 1'b0 || rd !== 32'hBEEF56AA) begin
            n_fail++;
            $display("FAIL unaligned_err: got err=%b rdata=%h want err=0 rdata=beef56aa", er, rd);
        end
        do_access(1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (rd !== 32'hBE225644) begin
            n_fail++;
            $display("FAIL unaligned_readback: got %h want be225644", rd);
        end
        do_access(1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, rd, er, lat, ac);
        do_access(1'b0, 32'h40, 4'b0000, 32'h0, rd, er, lat, ac);
        n_checks++;
        if (rd !== 32'hBE225644 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sel0_load: got %h err=%b want be225644 err=0", rd, er);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        req_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = '0;
        sel_i    = '0;
        wdata_i  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_full_word();
        test_byte_lanes();
        test_back_to_back();
        test_held_request();
        test_unaligned_sel();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
